// File: rtl/comb_decim_combiner.sv
// rtl/comb_decim_combiner.sv - decimation-by-8 combiner: phase tagging, pipelined branch adder tree, round/shift/saturate
module comb_decim_combiner #(
  parameter int IN_W       = 17,
  parameter int OUT_W      = 12,
  parameter int SHIFT      = 8,
  parameter int BRANCH_LAT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic                    phase_clr,
  input  logic [8*IN_W-1:0]       branch_bus,
  output logic signed [OUT_W-1:0] out_dec,
  output logic                    out_valid,
  output logic                    out_sat,
  output logic [2:0]              phase
);

  localparam int TW = IN_W + 4;
  localparam logic signed [TW-1:0] RND  = TW'(1) <<< (SHIFT - 1);
  localparam logic signed [TW-1:0] MAXV = TW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [TW-1:0] MINV = ~MAXV;

  logic [2:0]              phase_q, phase_d;
  logic                    tag_d;
  logic [BRANCH_LAT-1:0]   tag_q;
  logic signed [IN_W-1:0]  br [8];
  logic signed [IN_W:0]    s1_q [4];
  logic signed [IN_W:0]    s1_d [4];
  logic signed [IN_W+1:0]  s2_q [2];
  logic signed [IN_W+1:0]  s2_d [2];
  logic signed [IN_W+2:0]  s3_q, s3_d;
  logic                    v1_q, v2_q, v3_q;
  logic signed [TW-1:0]    t, q;
  logic signed [OUT_W-1:0] out_dec_q, out_dec_d;
  logic                    out_sat_q, out_sat_d, out_valid_q;

  // A phase_clr sample always counts as phase 0, so it can never produce a tag.
  always_comb begin
    phase_d = phase_q;
    tag_d   = 1'b0;
    if (phase_clr) begin
      phase_d = in_valid ? 3'd1 : 3'd0;
    end else if (in_valid) begin
      phase_d = phase_q + 3'd1;
      tag_d   = (phase_q == 3'd7);
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) br[i] = $signed(branch_bus[i*IN_W +: IN_W]);
    for (int j = 0; j < 4; j++) s1_d[j] = (IN_W+1)'(br[2*j]) + (IN_W+1)'(br[2*j+1]);
    for (int j = 0; j < 2; j++) s2_d[j] = (IN_W+2)'(s1_q[2*j]) + (IN_W+2)'(s1_q[2*j+1]);
    s3_d = (IN_W+3)'(s2_q[0]) + (IN_W+3)'(s2_q[1]);
  end

  // Adding half an LSB before the arithmetic shift rounds ties toward +inf.
  always_comb begin
    t = TW'(s3_q) + RND;
    q = t >>> SHIFT;
    out_sat_d = 1'b0;
    out_dec_d = q[OUT_W-1:0];
    if (q > MAXV) begin
      out_dec_d = MAXV[OUT_W-1:0];
      out_sat_d = 1'b1;
    end else if (q < MINV) begin
      out_dec_d = MINV[OUT_W-1:0];
      out_sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q     <= '0;
      tag_q       <= '0;
      for (int j = 0; j < 4; j++) s1_q[j] <= '0;
      for (int j = 0; j < 2; j++) s2_q[j] <= '0;
      s3_q        <= '0;
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      v3_q        <= 1'b0;
      out_dec_q   <= '0;
      out_sat_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      tag_q[0] <= tag_d;
      for (int i = 1; i < BRANCH_LAT; i++) tag_q[i] <= tag_q[i-1];
      v1_q <= tag_q[BRANCH_LAT-1];
      if (tag_q[BRANCH_LAT-1]) begin
        for (int j = 0; j < 4; j++) s1_q[j] <= s1_d[j];
      end
      v2_q <= v1_q;
      if (v1_q) begin
        for (int j = 0; j < 2; j++) s2_q[j] <= s2_d[j];
      end
      v3_q <= v2_q;
      if (v2_q) s3_q <= s3_d;
      out_valid_q <= v3_q;
      if (v3_q) begin
        out_dec_q <= out_dec_d;
        out_sat_q <= out_sat_d;
      end
    end
  end

  assign out_dec   = out_dec_q;
  assign out_sat   = out_sat_q;
  assign out_valid = out_valid_q;
  assign phase     = phase_q;

endmodule

// File: tb/tb_comb_decim_combiner.sv
// tb/tb_comb_decim_combiner.sv - scoreboard bench for comb_decim_combiner
module tb_comb_decim_combiner;
  localparam int IN_W  = 17;
  localparam int OUT_W = 12;
  localparam int SHIFT = 8;
  localparam int BL    = 3;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    in_valid;
  logic                    phase_clr;
  logic [8*IN_W-1:0]       branch_bus;
  logic signed [OUT_W-1:0] out_dec;
  logic                    out_valid;
  logic                    out_sat;
  logic [2:0]              phase;

  comb_decim_combiner #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .BRANCH_LAT(BL)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .phase_clr(phase_clr),
    .branch_bus(branch_bus), .out_dec(out_dec), .out_valid(out_valid),
    .out_sat(out_sat), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int dec;
    bit sat;
  } exp_t;

  exp_t exp_q[$];
  int   cap_q[$];
  int   strobe_edges[$];
  int   bv[8];
  int   edge_cnt = 0;
  int   m_phase = 0;
  int   checks = 0;
  int   failures = 0;
  int   strobe_cnt = 0;
  int   last_dec = 0;
  int   last_edge = 0;
  bit   last_sat = 1'b0;

  function automatic void model_round(input longint sum, output int d, output bit s);
    longint qv, maxv, minv;
    maxv = (longint'(1) <<< (OUT_W - 1)) - 1;
    minv = -maxv - 1;
    qv = (sum + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
    if (qv > maxv) begin
      d = int'(maxv); s = 1'b1;
    end else if (qv < minv) begin
      d = int'(minv); s = 1'b1;
    end else begin
      d = int'(qv); s = 1'b0;
    end
  endfunction

  task automatic set_bv(input int val);
    for (int i = 0; i < 8; i++) bv[i] = val;
  endtask

  task automatic rand_bv();
    for (int i = 0; i < 8; i++) bv[i] = int'($urandom_range(131071, 0)) - 65536;
  endtask

  // Drive one cycle, advance the reference model, then check any strobe against the scoreboard.
  task automatic step(input logic v, input logic clr);
    int     e;
    longint sum;
    exp_t   x;
    e = edge_cnt + 1;
    in_valid  = v;
    phase_clr = clr;
    for (int i = 0; i < 8; i++) branch_bus[i*IN_W +: IN_W] = IN_W'(bv[i]);
    if (!rst_n) begin
      cap_q.delete();
      exp_q.delete();
      m_phase = 0;
    end else begin
      if (cap_q.size() > 0 && cap_q[0] == e) begin
        void'(cap_q.pop_front());
        sum = 0;
        for (int i = 0; i < 8; i++) sum += longint'(bv[i]);
        model_round(sum, x.dec, x.sat);
        x.due = e + 3;
        exp_q.push_back(x);
      end
      if (clr) m_phase = v ? 1 : 0;
      else if (v) begin
        if (m_phase == 7) cap_q.push_back(e + BL);
        m_phase = (m_phase + 1) % 8;
      end
    end
    @(posedge clk);
    edge_cnt++;
    #1;
    if (out_valid) begin
      strobe_cnt++;
      last_dec  = int'(out_dec);
      last_sat  = out_sat;
      last_edge = edge_cnt;
      strobe_edges.push_back(edge_cnt);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe edge=%0d out_dec=%0d, required no out_valid", edge_cnt, out_dec);
      end else begin
        x = exp_q.pop_front();
        if (x.due !== edge_cnt || x.dec !== int'(out_dec) || x.sat !== out_sat) begin
          failures++;
          $display("FAIL scoreboard edge=%0d out_dec=%0d out_sat=%0b, required edge=%0d out_dec=%0d out_sat=%0b",
                   edge_cnt, out_dec, out_sat, x.due, x.dec, x.sat);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= edge_cnt) begin
      checks++;
      failures++;
      $display("FAIL missing_strobe edge=%0d out_valid=0, required out_valid=1 out_dec=%0d", edge_cnt, exp_q[0].dec);
      void'(exp_q.pop_front());
    end
    checks++;
    if (phase !== 3'(m_phase)) begin
      failures++;
      $display("FAIL phase edge=%0d got=%0d, required %0d", edge_cnt, phase, m_phase);
    end
  endtask

  task automatic run_group(input int val, input int exp_dec, input bit exp_sat, input string name);
    int k, n0;
    set_bv(val);
    n0 = strobe_cnt;
    repeat (8) step(1'b1, 1'b0);
    k = edge_cnt;
    repeat (3) step(1'b0, 1'b0);
    rand_bv();
    repeat (4) step(1'b0, 1'b0);
    checks++;
    if (strobe_cnt - n0 !== 1) begin
      failures++; $display("FAIL %s_strobes got=%0d, required 1", name, strobe_cnt - n0);
    end
    checks++;
    if (last_dec !== exp_dec) begin
      failures++; $display("FAIL %s_out_dec got=%0d, required %0d", name, last_dec, exp_dec);
    end
    checks++;
    if (last_sat !== exp_sat) begin
      failures++; $display("FAIL %s_out_sat got=%0b, required %0b", name, last_sat, exp_sat);
    end
    checks++;
    if (last_edge - k !== 6) begin
      failures++; $display("FAIL %s_latency got=%0d, required 6", name, last_edge - k);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_bv(0);
    repeat (3) step(1'b0, 1'b0);
    checks++;
    if (out_dec !== '0 || out_valid !== 1'b0 || out_sat !== 1'b0 || phase !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got dec=%0d valid=%0b sat=%0b phase=%0d, required all 0", out_dec, out_valid, out_sat, phase);
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0);
  endtask

  task automatic test_basic();
    run_group(100, 3, 1'b0, "basic");
    checks++;
    if (phase !== 3'd0) begin
      failures++; $display("FAIL basic_phase_wrap got=%0d, required 0", phase);
    end
  endtask

  task automatic test_saturation();
    run_group(65535, 2047, 1'b1, "sat_pos");
    run_group(-65536, -2048, 1'b0, "sat_neg");
  endtask

  task automatic test_rounding();
    run_group(16, 1, 1'b0, "round_128");
    run_group(15, 0, 1'b0, "round_120");
    run_group(-16, 0, 1'b0, "round_m128");
    run_group(-17, -1, 1'b0, "round_m136");
  endtask

  task automatic test_back_to_back();
    int n0, bad;
    strobe_edges.delete();
    n0 = strobe_cnt;
    repeat (64) begin
      rand_bv();
      step(1'b1, 1'b0);
    end
    repeat (7) begin
      rand_bv();
      step(1'b0, 1'b0);
    end
    checks++;
    if (strobe_cnt - n0 !== 8) begin
      failures++; $display("FAIL b2b_count got=%0d, required 8", strobe_cnt - n0);
    end
    bad = 0;
    for (int i = 1; i < strobe_edges.size(); i++)
      if (strobe_edges[i] - strobe_edges[i-1] != 8) bad++;
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL b2b_spacing bad_gaps=%0d, required 0", bad);
    end
  endtask

  task automatic test_phase_clr();
    int n0, k2;
    set_bv(100);
    n0 = strobe_cnt;
    repeat (3) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    checks++;
    if (phase !== 3'd0) begin
      failures++; $display("FAIL clr_idle_phase got=%0d, required 0", phase);
    end
    repeat (8) step(1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if (phase !== 3'd1) begin
      failures++; $display("FAIL clr_valid_phase got=%0d, required 1", phase);
    end
    repeat (7) step(1'b1, 1'b0);
    k2 = edge_cnt;
    repeat (7) step(1'b0, 1'b0);
    checks++;
    if (strobe_cnt - n0 !== 2) begin
      failures++; $display("FAIL clr_strobes got=%0d, required 2", strobe_cnt - n0);
    end
    checks++;
    if (last_edge - k2 !== 6) begin
      failures++; $display("FAIL clr_realigned_latency got=%0d, required 6", last_edge - k2);
    end
  endtask

  task automatic test_reset_midflight();
    int n0;
    run_group(100, 3, 1'b0, "pre_reset");
    set_bv(100);
    n0 = strobe_cnt;
    repeat (8) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 1'b0);
    checks++;
    if (out_dec !== '0 || out_valid !== 1'b0 || out_sat !== 1'b0 || phase !== 3'd0) begin
      failures++;
      $display("FAIL midflight_reset_state got dec=%0d valid=%0b sat=%0b phase=%0d, required all 0", out_dec, out_valid, out_sat, phase);
    end
    rst_n = 1'b1;
    repeat (10) step(1'b0, 1'b0);
    checks++;
    if (strobe_cnt !== n0 || out_dec !== '0) begin
      failures++; $display("FAIL midflight_discard strobes=%0d dec=%0d, required strobes=%0d dec=0", strobe_cnt - n0, out_dec, 0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    phase_clr  = 1'b0;
    branch_bus = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_rounding();
    test_back_to_back();
    test_phase_clr();
    test_reset_midflight();
    checks++;
    if (exp_q.size() !== 0) begin
      failures++; $display("FAIL leftover_expected got=%0d, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
